// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator placed directly ahead of conv_3x3.
//
// Takes an 8-bit raster-order activation stream. Two line buffers hold the previous two
// rows. Each output is one 3x3 window in row-major order:
// [0] = (r-1,c-1), [4] = centre, [8] = (r+1,c+1).
//
// Build option WINGEN_SAME_PAD_EN:
//   defined   - one-pixel zero "same" padding. One window per pixel (W*H per frame).
//               EOL and FLUSH cycles produce the right-edge and bottom-row windows.
//   undefined - valid-only windows (W-2)*(H-2). in_ready stays high for the whole frame.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   cfg_width, cfg_height  frame size, sampled on an accepted start (both must be >= 3)
//   start                  one-cycle frame start pulse; ignored while busy
//   in_valid/in_ready      input handshake; in_pixel is accepted when both are high
//   in_pixel               input activation
//   out_valid, out_pixels  registered window output; there is no downstream backpressure
//   out_row, out_col       centre coordinate of the window on out_pixels
//   busy                   a frame is in progress
//   frame_done             pulse coincident with the frame's last out_valid
module conv_window_gen #(
  parameter int unsigned MAX_W = 416,
  parameter int unsigned MAX_H = 416,
  parameter int unsigned CW    = $clog2(MAX_W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   cfg_width,
  input  logic [CW-1:0]   cfg_height,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_pixel,
  output logic            out_valid,
  output logic [0:8][7:0] out_pixels,
  output logic [CW-1:0]   out_row,
  output logic [CW-1:0]   out_col,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [CW-1:0] One   = CW'(1);
  localparam logic [CW-1:0] Two   = CW'(2);
  localparam logic [CW-1:0] Three = CW'(3);
  localparam logic [CW-1:0] MaxW  = CW'(MAX_W);
  localparam logic [CW-1:0] MaxH  = CW'(MAX_H);

  typedef enum logic [1:0] {StIdle, StRun, StEol, StFlush} state_e;
  typedef logic [0:2][7:0]       col_t;  // [0] top row .. [2] bottom row
  typedef logic [0:2][0:2][7:0]  win_t;  // [column][row], column 0 is leftmost

  state_e          state_q;
  logic [CW-1:0]   w_q, h_q, ri_q, ci_q;
  win_t            win_q;
  logic [7:0]      lb0 [MAX_W];  // row ri-2
  logic [7:0]      lb1 [MAX_W];  // row ri-1

  logic            accept, emit, last, shift;
  logic [CW-1:0]   rd_addr, c_row, c_col;
  logic [7:0]      lb0_rd, lb1_rd;
  col_t            emit_col, store_col;
  win_t            emit_win, store_win;
  logic [0:8][7:0] pix_next;
  logic            mask_t, mask_b, mask_l, mask_r;

  assign in_ready  = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid && in_ready;
  assign lb0_rd    = lb0[rd_addr];
  assign lb1_rd    = lb1[rd_addr];
  assign emit_win  = {win_q[1], win_q[2], emit_col};
  assign store_win = {win_q[1], win_q[2], store_col};

`ifdef WINGEN_SAME_PAD_EN
  logic [CW-1:0] nxt_col;
  assign nxt_col = ci_q + One;
`endif

  // Column selection and the emitted centre for the current cycle.
  always_comb begin
    rd_addr   = ci_q;
    emit_col  = {lb0_rd, lb1_rd, in_pixel};
    store_col = emit_col;
    shift     = accept;
    emit      = 1'b0;
    last      = 1'b0;
    c_row     = ri_q - One;
    c_col     = ci_q - One;
    unique case (state_q)
`ifdef WINGEN_SAME_PAD_EN
      StRun: emit = accept && (ri_q >= One) && (ci_q >= One);
      StEol: begin
        // The emitted window has a zero right column. The stored window instead preloads
        // column 0 of the last row. FLUSH needs that column, and RUN masks it out as
        // the left pad.
        rd_addr   = '0;
        emit_col  = '0;
        store_col = {lb0_rd, lb1_rd, 8'h00};
        shift     = 1'b1;
        emit      = 1'b1;
        c_row     = ri_q - Two;  // ri has already advanced past the row just finished
        c_col     = w_q - One;
      end
      StFlush: begin
        rd_addr   = (nxt_col < w_q) ? nxt_col : '0;
        emit_col  = (nxt_col < w_q) ? {lb0_rd, lb1_rd, 8'h00} : '0;
        store_col = emit_col;
        shift     = 1'b1;
        emit      = 1'b1;
        last      = (ci_q == w_q - One);
        c_row     = h_q - One;
        c_col     = ci_q;
      end
`else
      StRun: begin
        emit = accept && (ri_q >= Two) && (ci_q >= Two);
        last = emit && (ri_q == h_q - One) && (ci_q == w_q - One);
      end
`endif
      default: ;
    endcase
  end

  // Reorder to row-major and zero the padded edges based on the centre coordinate.
  always_comb begin
`ifdef WINGEN_SAME_PAD_EN
    mask_t = (c_row == '0);
    mask_b = (c_row == h_q - One);
    mask_l = (c_col == '0);
    mask_r = (c_col == w_q - One);
`else
    mask_t = 1'b0;
    mask_b = 1'b0;
    mask_l = 1'b0;
    mask_r = 1'b0;
`endif
    pix_next = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((r == 0 && mask_t) || (r == 2 && mask_b) ||
              (c == 0 && mask_l) || (c == 2 && mask_r))) begin
          pix_next[r*3+c] = emit_win[c][r];
        end
      end
    end
  end

  // Line buffers are written only on accept. They are not reset; stale rows are always
  // masked out as padding or never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[ci_q] <= lb1_rd;
      lb1[ci_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      w_q        <= '0;
      h_q        <= '0;
      ri_q       <= '0;
      ci_q       <= '0;
      win_q      <= '0;
      out_valid  <= 1'b0;
      out_pixels <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && last;
      if (emit) begin
        out_pixels <= pix_next;
        out_row    <= c_row;
        out_col    <= c_col;
      end
      if (shift) win_q <= store_win;
      unique case (state_q)
        StIdle: begin
          if (start && (cfg_width >= Three) && (cfg_height >= Three) &&
              (cfg_width <= MaxW) && (cfg_height <= MaxH)) begin
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            ri_q    <= '0;
            ci_q    <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            if (ci_q == w_q - One) begin
              ci_q <= '0;
`ifdef WINGEN_SAME_PAD_EN
              ri_q <= ri_q + One;
              if (ri_q >= One) state_q <= StEol;
`else
              if (ri_q == h_q - One) begin
                ri_q    <= '0;
                state_q <= StIdle;
              end else begin
                ri_q <= ri_q + One;
              end
`endif
            end else begin
              ci_q <= ci_q + One;
            end
          end
        end
`ifdef WINGEN_SAME_PAD_EN
        StEol: state_q <= (ri_q == h_q) ? StFlush : StRun;
        StFlush: begin
          if (ci_q == w_q - One) begin
            ci_q    <= '0;
            ri_q    <= '0;
            state_q <= StIdle;
          end else begin
            ci_q <= nxt_col;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

  localparam int unsigned MAX_W = 416;
  localparam int unsigned MAX_H = 416;
  localparam int unsigned CW    = $clog2(MAX_W + 1);
  localparam int Budget = 2000;

`ifdef WINGEN_SAME_PAD_EN
  localparam logic [0:8][7:0] FirstWin = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
  localparam logic [0:8][7:0] LastWin  = {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0,
                                          8'd0, 8'd0, 8'd0};
  localparam int FirstRc = 0;
  localparam int LastRc  = 3;
`else
  localparam logic [0:8][7:0] FirstWin = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
  localparam logic [0:8][7:0] LastWin  = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12,
                                          8'd14, 8'd15, 8'd16};
  localparam int FirstRc = 1;
  localparam int LastRc  = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   cfg_width, cfg_height;
  logic            start, in_valid, in_ready, out_valid, busy, frame_done;
  logic [7:0]      in_pixel;
  logic [0:8][7:0] out_pixels;
  logic [CW-1:0]   out_row, out_col;

  conv_window_gen #(.MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_pixels (out_pixels),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:8][7:0] pix;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;
    logic            last;
  } exp_t;

  exp_t            exp_q[$];
  int              n_cmp, n_err, n_win, n_done;
  logic [7:0]      img [0:63];
  int              cur_w, cur_h;
  logic [0:8][7:0] first_win, last_win;
  logic [CW-1:0]   first_row, first_col, last_row, last_col;
  bit              got_first;

  function automatic logic [7:0] px(input int r, input int c);
    if (r < 0 || r >= cur_h || c < 0 || c >= cur_w) return 8'h00;
    return img[r * cur_w + c];
  endfunction

  function automatic int exp_count(input int w, input int h);
`ifdef WINGEN_SAME_PAD_EN
    return w * h;
`else
    return (w - 2) * (h - 2);
`endif
  endfunction

  function automatic int exp_rdy_low(input int w, input int h);
`ifdef WINGEN_SAME_PAD_EN
    return (h - 1) + w;
`else
    return 0 * (w + h);
`endif
  endfunction

  task automatic load_image(input int w, input int h, input bit rnd);
    cur_w = w;
    cur_h = h;
    for (int i = 0; i < w * h; i++) img[i] = rnd ? 8'($urandom_range(1, 255)) : 8'(i + 1);
  endtask

  // Scoreboard: every expected window of the frame, in emission (raster) order.
  task automatic push_expected();
    exp_t e;
    bit   keep, is_last;
    for (int r = 0; r < cur_h; r++) begin
      for (int c = 0; c < cur_w; c++) begin
`ifdef WINGEN_SAME_PAD_EN
        keep    = 1'b1;
        is_last = (r == cur_h - 1) && (c == cur_w - 1);
`else
        keep    = (r >= 1) && (r <= cur_h - 2) && (c >= 1) && (c <= cur_w - 2);
        is_last = (r == cur_h - 2) && (c == cur_w - 2);
`endif
        if (keep) begin
          for (int k = 0; k < 9; k++) e.pix[k] = px(r + k / 3 - 1, c + k % 3 - 1);
          e.row  = CW'(r);
          e.col  = CW'(c);
          e.last = is_last;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      n_win++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_window: got pix=%h row=%0d col=%0d, want no window",
                 out_pixels, out_row, out_col);
      end else begin
        e = exp_q.pop_front();
        if (out_pixels !== e.pix || out_row !== e.row || out_col !== e.col ||
            frame_done !== e.last) begin
          n_err++;
          $display("FAIL window: got pix=%h row=%0d col=%0d done=%0b, want pix=%h row=%0d col=%0d done=%0b",
                   out_pixels, out_row, out_col, frame_done, e.pix, e.row, e.col, e.last);
        end
      end
      if (!got_first) begin
        got_first = 1'b1;
        first_win = out_pixels;
        first_row = out_row;
        first_col = out_col;
      end
      last_win = out_pixels;
      last_row = out_row;
      last_col = out_col;
    end else if (frame_done) begin
      n_err++;
      $display("FAIL frame_done_alone: got frame_done=1 out_valid=0, want coincident");
    end
    if (frame_done) n_done++;
  end

  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    cfg_width  = CW'(w);
    cfg_height = CW'(h);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic drive_frame(input int w, input int h, input bit rnd, input bit gaps,
                             input int restart_cyc, output int rdy_low, output int gap_viol,
                             output bit timeout);
    int idx, cyc;
    bit prev_gap;
    load_image(w, h, rnd);
    push_expected();
    n_win = 0; n_done = 0; got_first = 1'b0;
    rdy_low = 0; gap_viol = 0; idx = 0; cyc = 0; prev_gap = 1'b0;
    pulse_start(w, h);
    while ((idx < w * h || busy) && cyc < Budget) begin
      in_valid  = (idx < w * h) && !(gaps && (cyc % 2 == 1));
      in_pixel  = (idx < w * h) ? img[idx] : 8'h00;
      start     = (cyc == restart_cyc);
      cfg_width = (cyc == restart_cyc) ? CW'(w + 1) : CW'(w);
      @(negedge clk);
      if (prev_gap && out_valid) gap_viol++;
      prev_gap = busy && in_ready && !in_valid;
      if (busy && !in_ready) rdy_low++;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    cfg_width = CW'(w);
    timeout   = (cyc >= Budget);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    cfg_width = '0; cfg_height = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got v/busy/rdy/done=%b, want 0000",
               {out_valid, busy, in_ready, frame_done});
    end
    n_cmp++;
    if (out_pixels !== '0 || out_row !== '0 || out_col !== '0) begin
      n_err++;
      $display("FAIL reset_data: got pix=%h row=%0d col=%0d, want zeros",
               out_pixels, out_row, out_col);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int rl, gv; bit to;
    drive_frame(4, 4, 1'b0, 1'b0, -1, rl, gv, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got 1, want 0"); end
    n_cmp++;
    if (n_win !== exp_count(4, 4)) begin
      n_err++; $display("FAIL basic_count: got %0d, want %0d", n_win, exp_count(4, 4));
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done: got %0d, want 1", n_done); end
    n_cmp++;
    if (rl !== exp_rdy_low(4, 4)) begin
      n_err++; $display("FAIL basic_rdy_low: got %0d, want %0d", rl, exp_rdy_low(4, 4));
    end
    n_cmp++;
    if (first_win !== FirstWin || first_row !== CW'(FirstRc) || first_col !== CW'(FirstRc)) begin
      n_err++;
      $display("FAIL basic_first: got %h at (%0d,%0d), want %h at (%0d,%0d)",
               first_win, first_row, first_col, FirstWin, FirstRc, FirstRc);
    end
    n_cmp++;
    if (last_win !== LastWin || last_row !== CW'(LastRc) || last_col !== CW'(LastRc)) begin
      n_err++;
      $display("FAIL basic_last: got %h at (%0d,%0d), want %h at (%0d,%0d)",
               last_win, last_row, last_col, LastWin, LastRc, LastRc);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL basic_left: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_gaps();
    int rl, gv; bit to;
    drive_frame(4, 4, 1'b0, 1'b1, -1, rl, gv, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL gaps_timeout: got 1, want 0"); end
    n_cmp++;
    if (n_win !== exp_count(4, 4)) begin
      n_err++; $display("FAIL gaps_count: got %0d, want %0d", n_win, exp_count(4, 4));
    end
    n_cmp++;
    if (gv !== 0) begin n_err++; $display("FAIL gaps_idle_window: got %0d, want 0", gv); end
    n_cmp++;
    if (rl !== exp_rdy_low(4, 4)) begin
      n_err++; $display("FAIL gaps_rdy_low: got %0d, want %0d", rl, exp_rdy_low(4, 4));
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL gaps_left: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_small_cfg();
    n_win = 0;
    pulse_start(2, 4);
    in_valid = 1'b1; in_pixel = 8'h55;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL small_w: got busy=%b rdy=%b, want 0 0", busy, in_ready);
      end
    end
    in_valid = 1'b0;
    pulse_start(4, 2);
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL small_h: got busy=%b rdy=%b, want 0 0", busy, in_ready);
      end
    end
    n_cmp++;
    if (n_win !== 0) begin n_err++; $display("FAIL small_outputs: got %0d, want 0", n_win); end
  endtask

  task automatic test_double_start();
    int rl, gv; bit to;
    drive_frame(4, 4, 1'b0, 1'b0, 6, rl, gv, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL dstart_timeout: got 1, want 0"); end
    n_cmp++;
    if (n_win !== exp_count(4, 4) || n_done !== 1) begin
      n_err++;
      $display("FAIL dstart_count: got %0d windows %0d done, want %0d 1",
               n_win, n_done, exp_count(4, 4));
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL dstart_left: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int rl, gv; bit to;
    int ws [2] = '{5, 3};
    int hs [2] = '{3, 3};
    for (int f = 0; f < 2; f++) begin
      drive_frame(ws[f], hs[f], 1'b1, 1'b0, -1, rl, gv, to);
      n_cmp++;
      if (to !== 1'b0 || n_win !== exp_count(ws[f], hs[f]) || n_done !== 1) begin
        n_err++;
        $display("FAIL b2b_frame%0d: got to=%0b windows=%0d done=%0d, want 0 %0d 1",
                 f, to, n_win, n_done, exp_count(ws[f], hs[f]));
      end
      n_cmp++;
      if (rl !== exp_rdy_low(ws[f], hs[f]) || exp_q.size() !== 0) begin
        n_err++;
        $display("FAIL b2b_tail%0d: got rdy_low=%0d pending=%0d, want %0d 0",
                 f, rl, exp_q.size(), exp_rdy_low(ws[f], hs[f]));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int idx, cyc, rl, gv; bit to;
    load_image(4, 4, 1'b0);
    push_expected();
    pulse_start(4, 4);
    idx = 0; cyc = 0;
    while (idx < 10 && cyc < Budget) begin
      in_valid = 1'b1;
      in_pixel = img[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, in_ready, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_ctrl: got v/busy/rdy/done=%b, want 0000",
               {out_valid, busy, in_ready, frame_done});
    end
    n_cmp++;
    if (out_pixels !== '0 || out_row !== '0 || out_col !== '0) begin
      n_err++;
      $display("FAIL midrst_data: got pix=%h row=%0d col=%0d, want zeros",
               out_pixels, out_row, out_col);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_frame(4, 4, 1'b0, 1'b0, -1, rl, gv, to);
    n_cmp++;
    if (to !== 1'b0 || n_win !== exp_count(4, 4)) begin
      n_err++;
      $display("FAIL midrst_frame: got to=%0b windows=%0d, want 0 %0d",
               to, n_win, exp_count(4, 4));
    end
    n_cmp++;
    if (first_win !== FirstWin) begin
      n_err++; $display("FAIL midrst_first: got %h, want %h", first_win, FirstWin);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_win = 0; n_done = 0; got_first = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_small_cfg();
    test_double_start();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming 3x3 window generator that sits directly upstream of conv_3x3. It accepts an 8-bit activation stream in raster order and buffers two rows in line buffers. It emits one 3x3 window per output pixel, in the pixels[0:8] layout conv_3x3 expects, with one-pixel zero "same" padding. One window is produced for every input pixel position.

Parameters:
MAX_W, 416, largest supported image width; sizes the line buffers and the width counters
MAX_H, 416, largest supported image height; sizes the row counters
CW, $clog2(MAX_W+1), width of the cfg_width, cfg_height, out_row and out_col fields

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cfg_width  in  CW  image width W; sampled on an accepted start
cfg_height  in  CW  image height H; sampled on an accepted start
start  in  1  one-cycle pulse that begins a frame
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept in_pixel this cycle
in_pixel  in  8  input activation, raster order
out_valid  out  1  out_pixels holds a valid window
out_pixels  out  8 x [0:8]  window, row-major; [0] = (r-1,c-1), [4] = centre, [8] = (r+1,c+1)
out_row  out  CW  centre row of the current window
out_col  out  CW  centre column of the current window
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse, coincident with the frame's last out_valid

Behaviour:
- Reset (async): state=IDLE; in_ready, out_valid, busy, frame_done=0; out_pixels, out_row, out_col=0; all counters=0. Line-buffer RAM is not cleared.
- Accept condition: in_valid && in_ready. Input counters (ri, ci) advance on accept; ci wraps at W-1, and ri increments on wrap.
- Line buffers: two MAX_W x 8 RAMs.
  - Column c supplies rows ri-2 and ri-1; the new pixel supplies row ri.
  - The three values shift into a 3-column window register.
- States:
  - IDLE:
    - in_ready=0; busy=0.
    - start with W>=3 and H>=3 latches cfg and goes to RUN.
    - start with W<3 or H<3 is ignored.
  - RUN:
    - in_ready=1.
    - On accept of (ri,ci) with ri>=1 and ci>=1, emit the window centred on (ri-1, ci-1).
    - On accept of (ri, W-1) with ri>=1, go to EOL.
    - On accept of (H-1, W-1), go to EOL.
  - EOL:
    - One cycle; in_ready=0.
    - Shift a zero column into the window and emit the window centred on (ri-1, W-1).
    - Next state is RUN, or FLUSH if this was the last input row.
  - FLUSH:
    - in_ready=0.
    - Replay row H-1 from the line buffers for W cycles with a zero bottom row; emit centres (H-1, 0..W-1), right pad on the last.
    - Then go to IDLE with frame_done.
- Padding mask is applied at the output from the centre coordinates:
  - row 0: top row zeroed
  - row H-1: bottom row zeroed
  - col 0: left column zeroed
  - col W-1: right column zeroed
- Timing: out_valid and out_pixels are registered, valid the cycle after the accept or EOL/FLUSH cycle. No backpressure from downstream; conv_3x3 is always ready.
- in_valid gaps: no window is emitted for that cycle; windows resume unchanged.
- start while busy: ignored. in_valid while IDLE: ignored (in_ready=0).
- Output count per frame: exactly W*H windows.
- frame_done asserts in the same cycle as the final out_valid.

Optional Feature:
Macro WINGEN_SAME_PAD_EN.
- Defined: same-padding behaviour as above (EOL/FLUSH states, W*H windows).
- Undefined: valid-only windows.
  - in_ready stays 1 whenever busy.
  - No EOL or FLUSH states; no padding mask.
  - Windows are emitted only for centres 1..H-2 by 1..W-2, giving (W-2)*(H-2) windows.
  - frame_done coincides with the window centred on (H-2, W-2).

Test Plan:
- Macro defined; 4x4 frame, pixel=(4r+c+1), in_valid held high:
  - first window is [0,0,0,0,1,2,0,5,6] at (0,0); window at (1,1) is [1,2,3,5,6,7,9,10,11]; last is [11,12,0,15,16,0,0,0,0] at (3,3).
  - 16 out_valid total; in_ready low for 3 EOL cycles plus 4 FLUSH cycles; frame_done coincident with the (3,3) window.
- Same frame with in_valid deasserted every other cycle -> identical 16-window sequence and coordinates; no window during idle input cycles.
- start with cfg_width=2 -> stays IDLE, busy=0, in_ready=0, no outputs.
- Second start pulse mid-frame -> ignored; frame completes normally with 16 windows.
- Assert rst asynchronously mid-row 2 -> outputs clear immediately. A new 4x4 frame after release produces correct windows, with the first window equal to [0,0,0,0,1,2,0,5,6].
- Macro undefined; same 4x4 frame -> 4 windows, the first [1,2,3,5,6,7,9,10,11] at (1,1), the last centred on (2,2); in_ready never drops while busy.
